// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I/RV64I decode stage.
//   - Base opcode constants for the instruction classes the decoder knows.
//   - imm_fmt_t: immediate encoding format selected from the opcode.
//   - imm_fmt_of(): opcode -> immediate format.
//   - opcode_supported(): true for every opcode the pipeline implements.
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_t;

  function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_t fmt;
    case (opcode)
      OP_IMM, LOAD, JALR, SYSTEM: fmt = IMM_I;
      STORE:                      fmt = IMM_S;
      BRANCH:                     fmt = IMM_B;
      LUI, AUIPC:                 fmt = IMM_U;
      JAL:                        fmt = IMM_J;
      default:                    fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  // OP (register-register) carries no immediate but is still a legal opcode.
  function automatic logic opcode_supported(input logic [6:0] opcode);
    return (imm_fmt_of(opcode) != IMM_NONE) || (opcode == OP);
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// Integer register file, NUM_REGS x XLEN, two combinational read ports and
// one synchronous write port.
//   clk, reset         : clock, synchronous active-high clear of every entry
//   rs1, rs2           : read addresses
//   rs1_data, rs2_data : read data (x0 reads 0, write-back bypassed)
//   wb_en, wb_rd, wb_data : write port; writes to x0 are dropped
module rv_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int RA_W    = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] mem_reg [NUM_REGS];
  logic [RA_W-1:0] rd_idx  [2];
  logic [XLEN-1:0] rd_data [2];

  // Entry 0 is cleared on reset and never written, but the read ports also
  // force it to zero so x0 never depends on storage contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wb_en && (wb_rd != '0)) begin
      mem_reg[wb_rd] <= wb_data;
    end
  end

  assign rd_idx[0] = rs1;
  assign rd_idx[1] = rs2;

  // Same-cycle write-back is forwarded so decode never sees a stale operand.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      assign rd_data[gi] = (rd_idx[gi] == '0)                   ? '0      :
                           (wb_en && (wb_rd == rd_idx[gi]))     ? wb_data :
                                                                  mem_reg[rd_idx[gi]];
    end
  endgenerate

  assign rs1_data = rd_data[0];
  assign rs2_data = rd_data[1];

endmodule

// File: rtl/rv_decode_stage.sv
// Decode stage for the in-order RV32I/RV64I pipeline.
// Extracts instruction fields, builds the sign-extended immediate, reads the
// register file and presents the result through a one-entry ID/EX register.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : handshake from IF; in_instr, in_pc carried along
//   wb_en/wb_rd/wb_data   : register-file write port driven by WB
//   flush                 : drop the held bundle and any incoming instruction
//   out_valid/out_ready   : handshake towards EX
//   out_pc, out_rs1/2, out_rd, out_rs1/2_data, out_imm,
//   out_opcode, out_funct3, out_funct7 : registered decode bundle
//   out_illegal           : only when RV_DECODE_ILLEGAL_EN is defined
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NUM_REGS = 32,
  localparam int RA_W    = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [RA_W-1:0] out_rs1,
  output logic [RA_W-1:0] out_rs2,
  output logic [RA_W-1:0] out_rd,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7
`ifdef RV_DECODE_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);

  // Build the 32-bit immediate for the format, then sign-extend to XLEN.
  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr);
    logic [31:0] imm32;
    case (imm_fmt_of(instr[6:0]))
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    return XLEN'($signed(imm32));
  endfunction

  logic [RA_W-1:0] rs1_idx;
  logic [RA_W-1:0] rs2_idx;
  logic [RA_W-1:0] rd_idx;
  logic [XLEN-1:0] rs1_rdata;
  logic [XLEN-1:0] rs2_rdata;
  logic [XLEN-1:0] imm_next;
  logic            accept;

  logic            out_valid_reg;
  logic [XLEN-1:0] out_pc_reg;
  logic [RA_W-1:0] out_rs1_reg;
  logic [RA_W-1:0] out_rs2_reg;
  logic [RA_W-1:0] out_rd_reg;
  logic [XLEN-1:0] out_rs1_data_reg;
  logic [XLEN-1:0] out_rs2_data_reg;
  logic [XLEN-1:0] out_imm_reg;
  logic [6:0]      out_opcode_reg;
  logic [2:0]      out_funct3_reg;
  logic [6:0]      out_funct7_reg;

  // Only the low RA_W bits of each register field address the file.
  assign rs1_idx  = in_instr[15 +: RA_W];
  assign rs2_idx  = in_instr[20 +: RA_W];
  assign rd_idx   = in_instr[7 +: RA_W];
  assign imm_next = gen_imm(in_instr);

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  rv_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1      (rs1_idx),
    .rs2      (rs2_idx),
    .rs1_data (rs1_rdata),
    .rs2_data (rs2_rdata),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  // Flush beats accept; a stalled bundle keeps its fields but picks up any
  // write-back to its source registers so EX never consumes a stale operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg    <= 1'b0;
      out_pc_reg       <= '0;
      out_rs1_reg      <= '0;
      out_rs2_reg      <= '0;
      out_rd_reg       <= '0;
      out_rs1_data_reg <= '0;
      out_rs2_data_reg <= '0;
      out_imm_reg      <= '0;
      out_opcode_reg   <= '0;
      out_funct3_reg   <= '0;
      out_funct7_reg   <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg    <= 1'b1;
      out_pc_reg       <= in_pc;
      out_rs1_reg      <= rs1_idx;
      out_rs2_reg      <= rs2_idx;
      out_rd_reg       <= rd_idx;
      out_rs1_data_reg <= rs1_rdata;
      out_rs2_data_reg <= rs2_rdata;
      out_imm_reg      <= imm_next;
      out_opcode_reg   <= in_instr[6:0];
      out_funct3_reg   <= in_instr[14:12];
      out_funct7_reg   <= in_instr[31:25];
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end else if (out_valid_reg && wb_en) begin
      if ((wb_rd == out_rs1_reg) && (out_rs1_reg != '0)) begin
        out_rs1_data_reg <= wb_data;
      end
      if ((wb_rd == out_rs2_reg) && (out_rs2_reg != '0)) begin
        out_rs2_data_reg <= wb_data;
      end
    end
  end

`ifdef RV_DECODE_ILLEGAL_EN
  logic illegal_next;
  logic out_illegal_reg;
  logic uses_rd;
  logic uses_rs1;
  logic uses_rs2;

  // Which register fields an instruction actually references, by format.
  always_comb begin
    uses_rd  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (imm_fmt_of(in_instr[6:0]))
      IMM_I:        begin uses_rd = 1'b1; uses_rs1 = 1'b1; end
      IMM_S, IMM_B: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      IMM_U, IMM_J: begin uses_rd = 1'b1; end
      default: begin
        if (in_instr[6:0] == OP) begin
          uses_rd  = 1'b1;
          uses_rs1 = 1'b1;
          uses_rs2 = 1'b1;
        end
      end
    endcase
    illegal_next = !opcode_supported(in_instr[6:0]) || (in_instr[1:0] != 2'b11);
    // RV32E: bit 4 of a referenced field names a register that does not exist.
    if (NUM_REGS == 16) begin
      illegal_next = illegal_next || (uses_rd && in_instr[11]) ||
                     (uses_rs1 && in_instr[19]) || (uses_rs2 && in_instr[24]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_illegal_reg <= 1'b0;
    end else if (!flush && accept) begin
      out_illegal_reg <= illegal_next;
    end
  end

  assign out_illegal = out_illegal_reg;
`endif

  assign out_valid    = out_valid_reg;
  assign out_pc       = out_pc_reg;
  assign out_rs1      = out_rs1_reg;
  assign out_rs2      = out_rs2_reg;
  assign out_rd       = out_rd_reg;
  assign out_rs1_data = out_rs1_data_reg;
  assign out_rs2_data = out_rs2_data_reg;
  assign out_imm      = out_imm_reg;
  assign out_opcode   = out_opcode_reg;
  assign out_funct3   = out_funct3_reg;
  assign out_funct7   = out_funct7_reg;

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
Parametrised RV32I/RV64I decode stage for the in-order pipeline: field extraction, full immediate generation, and a 2R/1W integer register file with write-back bypass.
- Output is an ID/EX pipeline register with valid/ready handshake, flush, and stall-time operand refresh.
- Sits between the IF stage (upstream) and EX (downstream); write-back port is driven from WB.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediates sign-extended to XLEN.
NUM_REGS, 32, register count; power of two, 16 (RV32E) or 32.
RA_W, $clog2(NUM_REGS), register address width (derived, not overridden).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction PC
wb_en  in  1  register write enable
wb_rd  in  RA_W  write address
wb_data  in  XLEN  write data
flush  in  1  kill held and incoming instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  EX accepts bundle
out_pc  out  XLEN  registered PC
out_rs1, out_rs2, out_rd  out  RA_W  register indices
out_rs1_data, out_rs2_data  out  XLEN  operands
out_imm  out  XLEN  sign-extended immediate
out_opcode  out  7  opcode
out_funct3  out  3  funct3
out_funct7  out  7  funct7

Behaviour:
- Reset clears all registers, out_valid and every out_* to 0 on the next clk edge; any in-flight bundle is dropped.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Write on posedge when wb_en && wb_rd!=0.
  - Reads are combinational.
  - Bypass: if wb_en && wb_rd==rsN && rsN!=0, the read returns wb_data in the same cycle.
- Index fields: rsN/rd use the low RA_W bits of the instruction fields.
- Immediate, selected by opcode:
  - I-type (0010011, 0000011, 1100111, 1110011): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Any other opcode: 0.
  - All formats sign-extended from instr[31] to XLEN.
- Handshake (one-entry pipeline register, latency 1):
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready: load all out_* fields and set out_valid=1.
  - Else if out_ready: out_valid<=0.
- Stall (out_valid && !out_ready): all out_* fields hold, except operand refresh below.
- Operand refresh: while out_valid && !out_ready, if wb_en && wb_rd==out_rsN && out_rsN!=0, out_rsN_data<=wb_data.
- Flush has priority over accept: out_valid<=0, incoming instruction discarded; register file writes still occur.
- Simultaneous accept and wb to the same rs: the bypassed (new) value is captured.

Optional Feature:
RV_DECODE_ILLEGAL_EN
- With macro: adds output out_illegal (1 bit, registered alongside the bundle). It is set when any of the following holds; reset value 0.
  - opcode is not in the supported set;
  - instr[1:0]!=2'b11;
  - NUM_REGS==16 and any used index is >=16.
- Without macro: port absent; unsupported opcodes pass through with out_imm=0.

Decomposition:
- Shared package rv_pkg:
  - opcode localparams (OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, SYSTEM, OP);
  - imm_fmt_t enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE};
  - default XLEN.
- Sub-module rv_regfile: parameterised NUM_REGS x XLEN, 2 read / 1 write, with bypass and synchronous clear.
- Immediate generation stays inline as a function.

Test Plan:
- Write-back, then decode: wb x5=0x0000_1234, then decode addi x6,x5,-1 (0xFFF28313) -> out_rs1_data=0x1234, out_imm=0xFFFF_FFFF, out_rd=6, out_valid=1 one cycle after accept.
- Same-cycle bypass and x0: wb_en with x7=0xDEAD_BEEF in the same cycle as decode of add x8,x7,x0 -> out_rs1_data=0xDEADBEEF, out_rs2_data=0; a write to x0 then read -> 0.
- Immediate formats: sw 0xFE112E23 -> imm=0xFFFF_FFFC; beq 0xFE000EE3 -> imm=0xFFFF_FFFC; jal 0x0040006F -> imm=4; lui 0x123450B7 -> imm=0x1234_5000.
- Stall and refresh: hold out_ready=0 for 3 cycles with the bundle reading x5; wb x5=0x55 during the stall -> in_ready=0, out_rs1_data becomes 0x55, other fields stable.
- Flush: flush=1 with in_valid=1 and a held bundle -> out_valid=0 next cycle, incoming instruction never appears.
- Reset mid-stall: assert reset for 1 cycle -> out_valid=0, all outputs 0, x5 reads 0 afterwards; XLEN=64 run: addi imm -1 -> 0xFFFF_FFFF_FFFF_FFFF.
